// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word scheduler.
package uart_pkg;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} tx_sched_state_t;

    localparam int unsigned UART_WORD_BYTES = 4;

    function automatic logic [7:0] uart_xor_bytes(input logic [31:0] word);
        return word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; priority flips away from the winner on advance_i.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && (!req_i[1] || !prio_q)) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
        prio_d = prio_q;
        // Granting requester 0 hands priority to 1, and vice versa.
        if (advance_i) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/uart_word_tx_sched.sv
// Round-robin word scheduler feeding the UART byte transmitter, LSB byte first.
// Define UART_WORD_TX_CHECKSUM_EN to append an XOR checksum byte to every word.
module uart_word_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_word,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_word,
    output logic        req1_ready,
    output logic        tx_send_pulse,
    output logic [7:0]  tx_byte,
    input  logic        tx_byte_end,
    output logic        busy,
    output logic        grant_id,
    output logic        word_done,
    output logic        timeout_err
);

`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam logic [2:0] LastIdx = 3'(UART_WORD_BYTES);
`else
    localparam logic [2:0] LastIdx = 3'(UART_WORD_BYTES - 1);
`endif

    localparam int unsigned CntW = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(BYTE_TIMEOUT - 1);

    tx_sched_state_t state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            grant_id_q, grant_id_d;
    logic            timeout_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_send_pulse_q, busy_q, word_done_q, timeout_err_q;
    logic [1:0]      gnt;
    logic            advance;

    uart_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({req1_valid, req0_valid}),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    assign req0_ready = (state_q == StIdle) && gnt[0];
    assign req1_ready = (state_q == StIdle) && gnt[1];

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    advance    = 1'b1;
                    word_d     = gnt[1] ? req1_word : req0_word;
                    idx_d      = 3'd0;
                    grant_id_d = gnt[1];
                    state_d    = StSend;
                end
            end
            StSend: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (tx_byte_end) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end else if (BYTE_TIMEOUT != 0 && cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_byte_d = 8'h00;
        case (idx_d)
            3'd0: tx_byte_d = word_d[7:0];
            3'd1: tx_byte_d = word_d[15:8];
            3'd2: tx_byte_d = word_d[23:16];
            3'd3: tx_byte_d = word_d[31:24];
`ifdef UART_WORD_TX_CHECKSUM_EN
            3'd4: tx_byte_d = uart_xor_bytes(word_d);
`endif
            default: tx_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            word_q          <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            grant_id_q      <= 1'b0;
            tx_byte_q       <= 8'h00;
            tx_send_pulse_q <= 1'b0;
            busy_q          <= 1'b0;
            word_done_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            grant_id_q      <= grant_id_d;
            tx_byte_q       <= tx_byte_d;
            tx_send_pulse_q <= (state_d == StSend);
            busy_q          <= (state_d != StIdle);
            word_done_q     <= (state_d == StDone);
            timeout_err_q   <= timeout_d;
        end
    end

    assign tx_send_pulse = tx_send_pulse_q;
    assign tx_byte       = tx_byte_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign word_done     = word_done_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_word_tx_sched.sv
// Self-checking bench: directed and random words against a byte-list/round-robin model.
module tb_uart_word_tx_sched;

`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_word = '0, req1_word = '0;
    logic        req0_ready, req1_ready;
    logic        tx_send_pulse;
    logic [7:0]  tx_byte;
    logic        tx_byte_end = 1'b0;
    logic        busy, grant_id, word_done, timeout_err;

    int vectors = 0;
    int miscompares = 0;
    bit prio = 1'b0;

    uart_word_tx_sched #(.BYTE_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_word     (req0_word),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_word     (req1_word),
        .req1_ready    (req1_ready),
        .tx_send_pulse (tx_send_pulse),
        .tx_byte       (tx_byte),
        .tx_byte_end   (tx_byte_end),
        .busy          (busy),
        .grant_id      (grant_id),
        .word_done     (word_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int b);
        if (b < 4) return 8'((w >> (8 * b)) & 32'hFF);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tx_byte_end = 1'b0;
        tick();
        chk("rst_send_pulse", tx_send_pulse, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        prio = 1'b0;
    endtask

    // Present requests in an IDLE cycle and check the round-robin choice.
    task automatic offer(input bit v0, input bit v1, input logic [31:0] w0,
                         input logic [31:0] w1, input bit hold, output bit got, output bit gid);
        bit e0, e1;
        req0_valid = v0;
        req1_valid = v1;
        req0_word  = w0;
        req1_word  = w1;
        #1;
        e0 = v0 && (!v1 || prio == 1'b0);
        e1 = !e0 && v1;
        chk("ready0", req0_ready, e0);
        chk("ready1", req1_ready, e1);
        got = e0 || e1;
        gid = e1;
        if (got) prio = ~gid;
        tick();
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    // Act as the byte transmitter; returns early at the SEND cycle of byte stop_at.
    task automatic serve_word(input logic [31:0] w, input bit gid, input int stop_at,
                              input bit stray);
        int d;
        for (int b = 0; b < NB; b++) begin
            chk("send_pulse", tx_send_pulse, 1);
            chk("tx_byte", tx_byte, exp_byte(w, b));
            chk("grant_id", grant_id, gid);
            chk("busy", busy, 1);
            chk("ready_while_busy", {req1_ready, req0_ready}, 0);
            if (b == stop_at) return;
            if (stray && b == 1) begin
                tx_byte_end = 1'b1;
                tick();
                tx_byte_end = 1'b0;
            end else begin
                tick();
            end
            d = $urandom_range(0, 12);
            repeat (d) begin
                chk("wait_pulse", tx_send_pulse, 0);
                chk("tx_byte_hold", tx_byte, exp_byte(w, b));
                chk("wait_word_done", word_done, 0);
                tick();
            end
            tx_byte_end = 1'b1;
            tick();
            tx_byte_end = 1'b0;
        end
        chk("word_done", word_done, 1);
        chk("busy_in_done", busy, 1);
        chk("done_send_pulse", tx_send_pulse, 0);
        tick();
        chk("word_done_clear", word_done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        bit got, gid;
        logic [31:0] w0, w1;

        do_reset();

        // Single word from requester 0.
        offer(1'b1, 1'b0, 32'h12345678, 32'h0, 1'b0, got, gid);
        chk("t1_got", got, 1);
        serve_word(32'h12345678, 1'b0, NB, 1'b0);
        chk("t1_grant_after", grant_id, 0);

        // Stray byte end while idle.
        tx_byte_end = 1'b1;
        tick();
        tx_byte_end = 1'b0;
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_pulse", tx_send_pulse, 0);

        // Both requesters held: strict alternation starting with requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1, got, gid);
            chk("alt_order", gid, i % 2);
            serve_word(gid ? 32'h55555555 : 32'hAAAAAAAA, gid, NB, (i == 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Random request patterns and words.
        for (int i = 0; i < 16; i++) begin
            w0 = $urandom();
            w1 = $urandom();
            offer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w0, w1, 1'b0, got, gid);
            if (got) begin
                serve_word(gid ? w1 : w0, gid, NB, 1'($urandom_range(0, 1)));
            end else begin
                chk("no_req_busy", busy, 0);
                chk("no_req_pulse", tx_send_pulse, 0);
            end
        end

        // Watchdog: withhold the end of byte 1.
        w0 = $urandom();
        offer(1'b1, 1'b0, w0, 32'h0, 1'b0, got, gid);
        serve_word(w0, gid, 1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("to_early", timeout_err, 0);
            chk("to_busy", busy, 1);
        end
        tick();
        chk("to_pulse", timeout_err, 1);
        chk("to_idle", busy, 0);
        chk("to_no_done", word_done, 0);
        tick();
        chk("to_clear", timeout_err, 0);
        chk("to_no_done2", word_done, 0);
        // Priority already moved away from the abandoned requester.
        w0 = $urandom();
        w1 = $urandom();
        offer(1'b1, 1'b1, w0, w1, 1'b0, got, gid);
        chk("to_prio", gid, 1);
        serve_word(w1, gid, NB, 1'b0);

        // Reset in the middle of byte 2, then restart from byte 0.
        w0 = $urandom();
        offer(1'b1, 1'b0, w0, 32'h0, 1'b0, got, gid);
        serve_word(w0, gid, 2, 1'b0);
        do_reset();
        w0 = $urandom();
        w1 = $urandom();
        offer(1'b1, 1'b1, w0, w1, 1'b0, got, gid);
        chk("rst_prio", gid, 0);
        serve_word(w0, gid, NB, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_word_tx_sched.md
# uart_word_tx_sched

Two-requester scheduler in front of the single UART byte transmitter. It accepts 32-bit words from two independent requesters, arbitrates round-robin, and serializes each granted word LSB-byte-first into the transmitter's send-pulse/byte-end handshake. It also provides a per-byte watchdog and a word-complete pulse. It sits between the word-producing logic and the byte transmitter, which is its only consumer.

## Interface
- `BYTE_TIMEOUT`, default 512: max cycles from `tx_send_pulse` to `tx_byte_end`. 0 disables the watchdog. A nominal byte takes 10×32 + 2 cycles.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req0_valid` in 1: requester 0 has a word.
- `req0_word` in 32: requester 0 word.
- `req0_ready` out 1: requester 0 word accepted this cycle when valid is also high.
- `req1_valid`, `req1_word`, `req1_ready`: same for requester 1.
- `tx_send_pulse` out 1: one-cycle start to the byte transmitter.
- `tx_byte` out 8: byte to transmit, held stable until `tx_byte_end`.
- `tx_byte_end` in 1: one-cycle pulse from the transmitter when the stop bit completes.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 1: requester whose word is in flight (last granted).
- `word_done` out 1: one-cycle pulse when the last byte of a word completes.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: arbitrate.
  - SEND: assert `tx_send_pulse`.
  - WAIT: wait for `tx_byte_end`.
  - DONE: pulse `word_done`.
- IDLE:
  - `grant = valid0 & (!valid1 | prio==0) ? 0 : valid1 ? 1 : none`.
  - `reqN_ready = idle & grantN`. Ready may depend combinationally on valid.
  - On transfer: capture word, set `byte_idx = 0`, set `grant_id = N`, set `prio = ~N`, go to SEND.
- SEND (1 cycle): `tx_send_pulse = 1`, load watchdog counter, go to WAIT.
- WAIT, on `tx_byte_end`:
  - If `byte_idx == LAST`, go to DONE.
  - Otherwise increment `byte_idx` and go to SEND.
- DONE (1 cycle): `word_done = 1`, go to IDLE.
- `tx_byte = word[8*byte_idx +: 8]`, registered from the captured word. Byte order is 0x78, 0x56, 0x34, 0x12 for 0x12345678.
- Watchdog:
  - The counter counts WAIT cycles.
  - On reaching `BYTE_TIMEOUT` without `tx_byte_end`: `timeout_err = 1` for 1 cycle, the word is abandoned, no `word_done`, go to IDLE.
  - `prio` is already advanced at this point.
- `tx_byte_end` outside WAIT is ignored.
- A `reqN_valid` drop before transfer produces no transfer; arbitration is re-evaluated every IDLE cycle.
- Reset mid-word: the word is discarded and all state returns to reset values. The transmitter shares this reset.

## Timing
- Reset values:
  - State IDLE, `prio = 0`, `byte_idx = 0`.
  - `tx_send_pulse = 0`, `tx_byte = 0x00`.
  - `req*_ready = 0`, `busy = 0`, `grant_id = 0`.
  - `word_done = 0`, `timeout_err = 0`.
- Word accepted at cycle T:
  - First `tx_send_pulse` at T+1.
  - Each subsequent `tx_send_pulse` one cycle after the preceding `tx_byte_end`.
- `word_done` is asserted the cycle after the final `tx_byte_end`. The earliest next acceptance is the cycle after that.
- Back-to-back words therefore have exactly 2 idle cycles between the last `tx_byte_end` and the next `tx_send_pulse`.
- All outputs are registered except `req*_ready`.

## Configuration
- `UART_WORD_TX_CHECKSUM_EN`:
  - Defined: after the 4 data bytes, a 5th byte equal to the XOR of the 4 data bytes is sent (`LAST = 4`). `word_done` follows the checksum byte's `tx_byte_end`.
  - Undefined: `LAST = 3`, and no checksum logic is synthesized.

## Structure
- Shared package `uart_pkg`:
  - State enum `tx_sched_state_t` (IDLE, SEND, WAIT, DONE).
  - `UART_WORD_BYTES = 4`.
  - Function `uart_xor_bytes(logic [31:0])`.
- Sub-module `uart_rr_arb2`: 2-way round-robin grant with a priority register, updated on an `advance` input.

## Test plan
- Reset, then `req0_valid` with 0x12345678 and a transmitter model -> bytes 0x78, 0x56, 0x34, 0x12 in order, one `word_done`, `grant_id = 0`, `busy` low after DONE.
- Both valid, req0=0xAAAAAAAA and req1=0x55555555, held -> order req0, req1, req0 …. Ready is never high for both requesters at once.
- `UART_WORD_TX_CHECKSUM_EN` defined, word 0x12345678 -> 5th byte 0x08, and `word_done` follows it.
- Model withholds `tx_byte_end` with `BYTE_TIMEOUT = 16` -> `timeout_err` pulses 16 cycles after WAIT entry, state returns to IDLE, no `word_done`.
- Reset asserted during byte 2 -> all outputs at reset values next cycle, and the next accepted word restarts at byte 0.
- Stray `tx_byte_end` in IDLE and in SEND -> no state change and no byte skipped.
